// File: rtl/ir_frame_ctrl.sv
// ir_frame_ctrl
// Sequences the IR reader datapath. It synchronises the reader's "frame full"
// level, captures and validates the 32-bit frame, and pulses reader_clear.
// Good commands go into a one-entry valid/ready slot, which also carries a
// repeat-press flag. Saturating error and drop counters are kept.
// Optional feature macro: IR_EXT_ADDR_EN. When it is defined, the [15:8]
// address complement check is skipped and cmd_addr carries frame_data[15:0].
module ir_frame_ctrl #(
   parameter int CLEAR_CYCLES = 2,     // 1..15
   parameter int HOLD_TICKS   = 1200   // 1..2047
) (
   input  logic        IR_READER_CLK,
   input  logic        reset,
   input  logic        frame_avail,
   input  logic [31:0] frame_data,
   output logic        reader_clear,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [15:0] cmd_addr,
   output logic [7:0]  cmd_code,
   output logic        cmd_repeat,
   output logic [7:0]  err_count,
   output logic [7:0]  drop_count
);

   localparam logic [10:0] HOLD_MAX = 11'(HOLD_TICKS);
   localparam logic [3:0]  CLR_LAST = 4'(CLEAR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_CLEAR
   } state_t;

   state_t      state_reg, state_next;
   logic        avail_meta_reg, avail_s_reg, avail_d_reg;
   logic        avail_rise;
   logic [31:0] frame_reg;
   logic [3:0]  clr_cnt_reg;
   logic        clr_last;
   logic        commit;
   logic        ok_reg, rep_reg;
   logic [10:0] timer_reg;
   logic [15:0] last_addr_reg;
   logic [7:0]  last_code_reg;
   logic        frame_ok, frame_rep;
   logic [15:0] frame_addr;
   logic [7:0]  frame_code;
   logic [7:0]  code_pair;
   logic        load_slot, xfer;

   // Per-bit complement test of the command byte against its inverted copy
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_code_pair
         assign code_pair[gi] = frame_reg[24+gi] ^ frame_reg[16+gi];
      end
   endgenerate

`ifdef IR_EXT_ADDR_EN
   // Extended address: all 16 low bits are address, no complement byte
   assign frame_ok   = &code_pair;
   assign frame_addr = frame_reg[15:0];
`else
   logic [7:0] addr_pair;

   // Per-bit complement test of the address byte against its inverted copy
   generate
      for (gi = 0; gi < 8; gi++) begin : g_addr_pair
         assign addr_pair[gi] = frame_reg[8+gi] ^ frame_reg[gi];
      end
   endgenerate

   assign frame_ok   = (&code_pair) & (&addr_pair);
   assign frame_addr = {8'h00, frame_reg[7:0]};
`endif

   assign frame_code = frame_reg[23:16];
   // Repeat uses the previous good frame; the timer is HOLD_MAX after reset
   assign frame_rep  = (timer_reg < HOLD_MAX) && (frame_addr == last_addr_reg) &&
                       (frame_code == last_code_reg);
   assign avail_rise = avail_s_reg & ~avail_d_reg;
   assign clr_last   = (clr_cnt_reg == CLR_LAST);
   assign xfer       = cmd_valid & cmd_ready;
   assign load_slot  = commit & ok_reg & (~cmd_valid | cmd_ready);

   // Two-stage synchroniser plus a delayed copy for rising-edge detection
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset) begin
         avail_meta_reg <= 1'b0;
         avail_s_reg    <= 1'b0;
         avail_d_reg    <= 1'b0;
      end else begin
         avail_meta_reg <= frame_avail;
         avail_s_reg    <= avail_meta_reg;
         avail_d_reg    <= avail_s_reg;
      end
   end

   // State register
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic, reader clear pulse and commit strobe
   always_comb begin
      state_next   = state_reg;
      reader_clear = 1'b0;
      commit       = 1'b0;
      case (state_reg)
         ST_IDLE:  if (avail_rise) state_next = ST_CHECK;
         ST_CHECK: state_next = ST_CLEAR;
         ST_CLEAR: begin
            reader_clear = 1'b1;
            if (clr_last) begin
               commit     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   // Frame capture on the start edge, and the verdict while in CHECK
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset) begin
         frame_reg <= 32'h0;
         ok_reg    <= 1'b0;
         rep_reg   <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE && avail_rise) frame_reg <= frame_data;
         if (state_reg == ST_CHECK) begin
            ok_reg  <= frame_ok;
            rep_reg <= frame_rep;
         end
      end
   end

   // Counts the cycles spent in CLEAR
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset)                  clr_cnt_reg <= 4'd0;
      else if (state_reg != ST_CLEAR) clr_cnt_reg <= 4'd0;
      else                         clr_cnt_reg <= clr_cnt_reg + 4'd1;
   end

   // Repeat window timer and the remembered last good frame
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset) begin
         timer_reg     <= HOLD_MAX;
         last_addr_reg <= 16'h0;
         last_code_reg <= 8'h0;
      end else if (commit && ok_reg) begin
         timer_reg     <= 11'd0;
         last_addr_reg <= frame_addr;
         last_code_reg <= frame_code;
      end else if (timer_reg < HOLD_MAX) begin
         timer_reg <= timer_reg + 11'd1;
      end
   end

   // Command slot: reload wins over the transfer that empties it
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset) begin
         cmd_valid  <= 1'b0;
         cmd_addr   <= 16'h0;
         cmd_code   <= 8'h0;
         cmd_repeat <= 1'b0;
      end else if (load_slot) begin
         cmd_valid  <= 1'b1;
         cmd_addr   <= frame_addr;
         cmd_code   <= frame_code;
         cmd_repeat <= rep_reg;
      end else if (xfer) begin
         cmd_valid  <= 1'b0;
      end
   end

   // Saturating statistics, updated on the commit edge
   always_ff @(posedge IR_READER_CLK or negedge reset) begin
      if (!reset) begin
         err_count  <= 8'd0;
         drop_count <= 8'd0;
      end else if (commit) begin
         if (!ok_reg) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end else if (cmd_valid && !cmd_ready) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ir_frame_ctrl.sv
// Self-checking bench for ir_frame_ctrl. A frame-level model predicts
// every output from the frame start time and the decoding rules, and the
// outputs are compared against it on every falling edge.
// Honours IR_EXT_ADDR_EN the same way as the design.
module tb_ir_frame_ctrl;

   localparam int CC   = 2;
   localparam int HOLD = 1200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_avail = 1'b0;
   logic [31:0] frame_data = 32'h0;
   logic        cmd_ready = 1'b0;
   logic        reader_clear, cmd_valid, cmd_repeat;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_code, err_count, drop_count;

   ir_frame_ctrl #(.CLEAR_CYCLES(CC), .HOLD_TICKS(HOLD)) dut (
      .IR_READER_CLK(clk),
      .reset(reset),
      .frame_avail(frame_avail),
      .frame_data(frame_data),
      .reader_clear(reader_clear),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr),
      .cmd_code(cmd_code),
      .cmd_repeat(cmd_repeat),
      .err_count(err_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          n;      // edge after which frame_avail rose
   } pend_t;

   pend_t       pend_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          rand_ready = 1'b0;

   // model state
   bit          m_valid = 1'b0;
   logic [15:0] m_addr = 16'h0;
   logic [7:0]  m_code = 8'h0;
   bit          m_rep = 1'b0;
   int          m_err = 0;
   int          m_drop = 0;
   bit          have_last = 1'b0;
   logic [15:0] last_addr = 16'h0;
   logic [7:0]  last_code = 8'h0;
   int          last_c = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit f_ok(input logic [31:0] d);
      bit ok;
      ok = (d[31:24] == ~d[23:16]);
`ifndef IR_EXT_ADDR_EN
      ok = ok && (d[15:8] == ~d[7:0]);
`endif
      return ok;
   endfunction

   function automatic logic [15:0] f_addr(input logic [31:0] d);
`ifdef IR_EXT_ADDR_EN
      return d[15:0];
`else
      return {8'h00, d[7:0]};
`endif
   endfunction

   // Frame-level model: a frame started after edge n commits on edge n+4+CC
   always @(posedge clk or negedge reset) begin : model
      pend_t       p;
      bit          xfer, loaded, ok;
      logic [15:0] a;
      logic [7:0]  c;
      if (!reset) begin
         pend_q.delete();
         m_valid = 0; m_addr = 0; m_code = 0; m_rep = 0;
         m_err = 0; m_drop = 0; have_last = 0;
      end else begin
         cyc++;
         xfer   = m_valid && (cmd_ready === 1'b1);
         loaded = 0;
         if (pend_q.size() > 0 && pend_q[0].n + 4 + CC == cyc) begin
            p  = pend_q.pop_front();
            ok = f_ok(p.data);
            a  = f_addr(p.data);
            c  = p.data[23:16];
            if (ok) begin
               if (!m_valid || xfer) begin
                  m_valid = 1;
                  m_addr  = a;
                  m_code  = c;
                  m_rep   = have_last && ((p.n + 3 - last_c) < HOLD) &&
                            (a == last_addr) && (c == last_code);
                  loaded  = 1;
               end else if (m_drop < 255) begin
                  m_drop++;
               end
               have_last = 1; last_c = cyc; last_addr = a; last_code = c;
            end else if (m_err < 255) begin
               m_err++;
            end
         end
         if (xfer && !loaded) m_valid = 0;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin : compare
      bit rc_exp;
      rc_exp = 0;
      foreach (pend_q[i])
         if (pend_q[i].n + 4 <= cyc && cyc <= pend_q[i].n + 3 + CC) rc_exp = 1;
      check("reader_clear", reader_clear, rc_exp);
      check("cmd_valid", cmd_valid, m_valid);
      check("err_count", err_count, m_err);
      check("drop_count", drop_count, m_drop);
      if (m_valid) begin
         check("cmd_addr", cmd_addr, m_addr);
         check("cmd_code", cmd_code, m_code);
         check("cmd_repeat", cmd_repeat, m_rep);
      end
   end

   // Random consumer backpressure during the random phase
   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         cmd_ready = 1'($urandom_range(0, 1));
      end
   end

   // Drive one frame; the next call starts sp edges after this one
   task automatic send(input logic [31:0] d, input int sp);
      @(posedge clk);
      #1;
      frame_avail = 1'b1;
      frame_data  = d;
      pend_q.push_back('{d, cyc});
      $display("frame %08h start cycle %0d", d, cyc);
      repeat (2) @(posedge clk);
      #1 frame_avail = 1'b0;
      repeat (sp - 3) @(posedge clk);
   endtask

   task automatic send_get(input logic [31:0] d, input int sp, output bit got,
                           output logic [15:0] a, output logic [7:0] c, output logic r);
      bit g;
      logic [15:0] ta;
      logic [7:0] tc;
      logic tr;
      g = 0; ta = 0; tc = 0; tr = 0;
      fork
         send(d, sp);
         begin
            for (int k = 0; k < 20 && !g; k++) begin
               @(negedge clk);
               if (cmd_valid) begin
                  g = 1; ta = cmd_addr; tc = cmd_code; tr = cmd_repeat;
               end
            end
         end
      join
      got = g; a = ta; c = tc; r = tr;
   endtask

   initial begin
      #(10 * 80000);
      $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
      $fatal(1);
   end

   localparam logic [31:0] F_GOOD = 32'hEF10_FB04;
   localparam logic [31:0] F_BAD  = 32'hEE10_FB04;
   localparam logic [31:0] F_A    = 32'hDE21_F906;
   localparam logic [31:0] F_B    = 32'hCC33_FA05;

   initial begin
      bit          got, found;
      logic [15:0] a;
      logic [7:0]  c;
      logic        r;
      int          n0, rc, vcnt, vfirst;
      logic [7:0]  pa[4];
      logic [7:0]  pc[3];
      logic [31:0] d;
      int          sp;

      pa[0] = 8'h04; pa[1] = 8'h06; pa[2] = 8'hA5; pa[3] = 8'h3C;
      pc[0] = 8'h10; pc[1] = 8'h21; pc[2] = 8'h7E;

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset cmd_valid", cmd_valid, 1'b0);
      check("reset reader_clear", reader_clear, 1'b0);
      check("reset err_count", err_count, 8'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 cmd_ready = 1'b1;

      // first frame: exact latency and pulse widths
      rc = 0; vcnt = 0; vfirst = -1;
      fork
         send(F_GOOD, 12);
         begin
            @(posedge clk);
            #2 n0 = cyc;
            for (int k = 1; k <= 10; k++) begin
               @(negedge clk);
               if (reader_clear) rc++;
               if (cmd_valid) begin
                  vcnt++;
                  if (vfirst < 0) begin
                     vfirst = cyc - n0; a = cmd_addr; c = cmd_code; r = cmd_repeat;
                  end
               end
            end
         end
      join
      check("first reader_clear cycles", rc, 2);
      check("first valid latency", vfirst, 6);
      check("first valid cycles", vcnt, 1);
      check("first cmd_addr", a, 16'h0004);
      check("first cmd_code", c, 8'h10);
      check("first cmd_repeat", r, 1'b0);

      // repeat inside and outside the hold window
      repeat (488) @(posedge clk);
      send_get(F_GOOD, 12, got, a, c, r);
      check("repeat500 got", got, 1'b1);
      check("repeat500 cmd_repeat", r, 1'b1);
      repeat (1300) @(posedge clk);
      send_get(F_GOOD, 12, got, a, c, r);
      check("repeat1300 got", got, 1'b1);
      check("repeat1300 cmd_repeat", r, 1'b0);

      // invalid frames and err saturation
      send(F_BAD, 10);
      @(negedge clk);
      check("bad err_count", err_count, 8'd1);
      check("bad no valid", cmd_valid, 1'b0);
      for (int i = 0; i < 300; i++) send(F_BAD, 5);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("err saturated", err_count, 8'd255);

      // slot full: second good frame dropped
      cmd_ready = 1'b0;
      send(F_A, 10);
      send(F_B, 10);
      @(negedge clk);
      check("held cmd_valid", cmd_valid, 1'b1);
      check("held cmd_addr", cmd_addr, 16'h0006);
      check("held cmd_code", cmd_code, 8'h21);
      check("drop_count", drop_count, 8'd1);
      cmd_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("drained cmd_valid", cmd_valid, 1'b0);

      // reset while a frame is in CLEAR, with a command held in the slot
      cmd_ready = 1'b0;
      send(F_A, 10);
      found = 0;
      fork
         send(F_A, 10);
         begin
            for (int k = 0; k < 20 && !found; k++) begin
               @(negedge clk);
               if (reader_clear) found = 1;
            end
            check("clear seen before reset", found, 1'b1);
            #2 reset = 1'b0;
            #1;
            check("rst reader_clear", reader_clear, 1'b0);
            check("rst cmd_valid", cmd_valid, 1'b0);
            check("rst err_count", err_count, 8'd0);
            check("rst drop_count", drop_count, 8'd0);
            check("rst cmd_addr", cmd_addr, 16'h0);
            check("rst cmd_code", cmd_code, 8'h0);
         end
      join
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      cmd_ready = 1'b1;
      send_get(F_A, 12, got, a, c, r);
      check("post-reset got", got, 1'b1);
      check("post-reset cmd_addr", a, 16'h0006);
      check("post-reset cmd_repeat", r, 1'b0);

      // extended-address frame
      send_get(32'hEF10_1234, 12, got, a, c, r);
`ifdef IR_EXT_ADDR_EN
      check("ext got", got, 1'b1);
      check("ext cmd_addr", a, 16'h1234);
      check("ext err_count", err_count, 8'd0);
`else
      check("ext got", got, 1'b0);
      check("ext err_count", err_count, 8'd1);
`endif

      // random phase
      rand_ready = 1'b1;
      for (int i = 0; i < 250; i++) begin
         a = {8'h00, pa[$urandom_range(0, 3)]};
         c = pc[$urandom_range(0, 2)];
         d = {~c, c, ~a[7:0], a[7:0]};
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4: d = d ^ (32'h1 << $urandom_range(0, 31));
            5, 6, 7:       d = $urandom;
            default:       ;
         endcase
         sp = ($urandom_range(0, 19) == 0) ? $urandom_range(1000, 1400) : $urandom_range(5, 12);
         send(d, sp);
      end
      rand_ready = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_frame_ctrl.md
# ir_frame_ctrl

Controller that sequences the IR reader datapath: it detects a completed 32-bit frame from the IR reader, captures and validates it, clears the reader for the next frame, and hands decoded commands to the rest of the design over a valid/ready handshake. It sits between the IR reader and the main top-level command consumer, in the IR_READER_CLK (10 kHz) domain. It also flags repeat presses and keeps saturating error/drop statistics.

## Interface
- CLEAR_CYCLES, 2: cycles reader_clear is held high after each frame (1..15)
- HOLD_TICKS, 1200: repeat window in clocks, about 120 ms at 10 kHz (1..2047)
- IR_READER_CLK  in  1  sole clock, 10 kHz
- reset  in  1  asynchronous, active-low reset
- frame_avail  in  1  reader "frame full" level, asynchronous to the clock
- frame_data  in  32  reader shift-register contents, stable while frame_avail is high
- reader_clear  out  1  drives the reader reset; active-high
- cmd_valid  out  1  command slot occupied
- cmd_ready  in  1  consumer accepts the command
- cmd_addr  out  16  address field
- cmd_code  out  8  command field
- cmd_repeat  out  1  same addr/code as the last good frame, within the window
- err_count  out  8  invalid frames, saturating at 255
- drop_count  out  8  good frames lost because the slot was full, saturating at 255

## Operation
- Field map: [7:0] addr, [15:8] ~addr, [23:16] code, [31:24] ~code.
- A frame is valid if and only if [31:24] == ~[23:16] and (without IR_EXT_ADDR_EN) [15:8] == ~[7:0].
- frame_avail passes through a 2-FF synchronizer. A rising edge of the synchronized signal (avail_s) starts a frame.
- States:
  - IDLE: on an avail_s rise, latch frame_data and go to CHECK.
  - CHECK: evaluate validity and the repeat condition, then go to CLEAR.
  - CLEAR: hold reader_clear=1 for CLEAR_CYCLES cycles, then go to IDLE. On the last CLEAR cycle, commit the result:
    - invalid: err_count += 1;
    - valid and slot free (or being emptied this same edge): load the slot and set cmd_valid;
    - valid and slot full with no transfer: drop_count += 1, outputs unchanged.
- Repeat timer: an 11-bit counter. It resets to 0 on every valid frame's commit and increments each clock, saturating at HOLD_TICKS.
  - cmd_repeat=1 when the timer < HOLD_TICKS and addr/code equal the last valid frame.
  - The comparison uses the frame before the update.
  - The first valid frame after reset always has cmd_repeat=0, because the timer resets to HOLD_TICKS.
- Transfer happens on any edge where cmd_valid and cmd_ready are both high. cmd_valid falls the next cycle unless a reload occurs on the same edge, which keeps it high with new fields.
- cmd_addr/cmd_code/cmd_repeat are held stable while cmd_valid is high.
- Edges on avail_s outside IDLE are ignored; the frame is lost uncounted.
- Reset (any time, including mid-CLEAR): state=IDLE and every output is 0. The synchronizer and the last-frame registers clear; the repeat timer is set to HOLD_TICKS.

## Timing
- frame_avail rises → avail_s high after 2 edges → CHECK +1 → CLEAR +1 → cmd_valid high 4+CLEAR_CYCLES edges after frame_avail rises (6 by default).
- reader_clear is high exactly CLEAR_CYCLES consecutive cycles per frame, valid or not.
- Minimum frame-to-frame spacing handled: 3+CLEAR_CYCLES cycles.
- Counters update on the commit edge and never wrap.
- cmd_ready is combinationally ignored; it is only sampled at clock edges.

## Configuration
- IR_EXT_ADDR_EN:
  - defined: the [15:8] check is skipped (extended address) and cmd_addr = frame_data[15:0].
  - undefined: the address complement is checked and cmd_addr = {8'h00, frame_data[7:0]}.

## Test plan
- Reset, then frame 32'hEF10_FB04 (addr 04, code 10) with cmd_ready=1 → reader_clear high 2 cycles; cmd_valid for 1 cycle, 6 edges after avail; cmd_addr=0004, cmd_code=10, cmd_repeat=0.
- Same frame again 500 ticks later → cmd_repeat=1. Same frame again 1300 ticks after that → cmd_repeat=0.
- Frame 32'hEE10_FB04 (bad ~code) → no cmd_valid, err_count=1, reader_clear still pulsed. Repeat 300 times → err_count holds at 255.
- cmd_ready=0, two good frames → first held stable, drop_count=1. Then cmd_ready=1 → one transfer, cmd_valid drops.
- Frame 32'hEF10_1234: IR_EXT_ADDR_EN undefined → err_count+1; defined → cmd_addr=1234.
- Assert reset during CLEAR → reader_clear, cmd_valid and both counters are 0 immediately. A following good frame decodes normally with cmd_repeat=0.
